// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared fetch-stage constants, fetch FSM encoding and tag helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] c_nop_inst   = 32'h0000_0013;
  localparam logic [2:0]  c_bubble_tag = 3'd0;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  // Tags cycle 1..7 so that 0 always identifies a bubble.
  function automatic logic [2:0] next_tag(input logic [2:0] tag);
    return (tag == 3'd7) ? 3'd1 : tag + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : Instruction fetch with stall skid buffer and redirect/discard FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                     PC_WIDTH   = 32,
  parameter int                     ADDR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Stall,
  input  logic                  i_Redirect,
  input  logic [PC_WIDTH-1:0]   i_RedirectPC,
  output logic                  o_MemRd,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  input  logic [31:0]           i_MemData,
  input  logic                  i_MemReady,
  output logic [PC_WIDTH-1:0]   o_PC,
  output logic [31:0]           o_Inst,
  output logic [2:0]            o_DbgTag
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [31:0]         hold_q, hold_d;
  logic [2:0]          tag_q, tag_d;
  logic [PC_WIDTH-1:0] slot_pc_q, slot_pc_d;
  logic [31:0]         slot_inst_q, slot_inst_d;
  logic [2:0]          slot_tag_q, slot_tag_d;

  logic [PC_WIDTH-1:0] w_redirect_pc;
  logic [PC_WIDTH-1:0] w_pc_plus4;

  assign w_redirect_pc = i_RedirectPC & ~PC_WIDTH'(3);
  assign w_pc_plus4    = pc_q + PC_WIDTH'(4);

  assign o_MemRd   = !i_Reset && (state_q != S_HOLD);
  assign o_MemAddr = ADDR_WIDTH'(pc_q);
  assign o_PC      = slot_pc_q;
  assign o_Inst    = slot_inst_q;
  assign o_DbgTag  = slot_tag_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    hold_d      = hold_q;
    tag_d       = tag_q;
    slot_pc_d   = slot_pc_q;
    slot_inst_d = slot_inst_q;
    slot_tag_d  = slot_tag_q;

    // A redirect always empties the slot, even under stall.
    if (i_Redirect) begin
      slot_pc_d   = '0;
      slot_inst_d = c_nop_inst;
      slot_tag_d  = c_bubble_tag;
    end

    unique case (state_q)
      S_FETCH: begin
        if (i_Redirect) begin
          if (i_MemReady) begin
            pc_d = w_redirect_pc;
          end else begin
            target_d = w_redirect_pc;
            state_d  = S_DISCARD;
          end
        end else if (i_MemReady && !i_Stall) begin
          slot_pc_d   = pc_q;
          slot_inst_d = i_MemData;
          slot_tag_d  = tag_q;
          tag_d       = next_tag(tag_q);
          pc_d        = w_pc_plus4;
        end else if (i_MemReady) begin
          hold_d  = i_MemData;
          pc_d    = w_pc_plus4;
          state_d = S_HOLD;
        end else if (!i_Stall) begin
          slot_pc_d   = '0;
          slot_inst_d = c_nop_inst;
          slot_tag_d  = c_bubble_tag;
        end
      end

      S_HOLD: begin
        if (i_Redirect) begin
          pc_d    = w_redirect_pc;
          state_d = S_FETCH;
        end else if (!i_Stall) begin
          slot_pc_d   = pc_q - PC_WIDTH'(4);
          slot_inst_d = hold_q;
          slot_tag_d  = tag_q;
          tag_d       = next_tag(tag_q);
          state_d     = S_FETCH;
        end
      end

      S_DISCARD: begin
        if (!i_Stall) begin
          slot_pc_d   = '0;
          slot_inst_d = c_nop_inst;
          slot_tag_d  = c_bubble_tag;
        end
        if (i_Redirect) begin
          target_d = w_redirect_pc;
        end
        if (i_MemReady) begin
          pc_d    = i_Redirect ? w_redirect_pc : target_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      target_q    <= '0;
      hold_q      <= '0;
      tag_q       <= 3'd1;
      slot_pc_q   <= '0;
      slot_inst_q <= c_nop_inst;
      slot_tag_q  <= c_bubble_tag;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      hold_q      <= hold_d;
      tag_q       <= tag_d;
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
      slot_tag_q  <= slot_tag_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Directed and randomized checks of fetch_stage against a PC/tag model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Stall = 1'b0;
  logic        i_Redirect = 1'b0;
  logic [31:0] i_RedirectPC = '0;
  logic        o_MemRd;
  logic [31:0] o_MemAddr;
  logic [31:0] i_MemData;
  logic        i_MemReady = 1'b0;
  logic [31:0] o_PC;
  logic [31:0] o_Inst;
  logic [2:0]  o_DbgTag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_Clock     (clk),
    .i_Reset     (i_Reset),
    .i_Stall     (i_Stall),
    .i_Redirect  (i_Redirect),
    .i_RedirectPC(i_RedirectPC),
    .o_MemRd     (o_MemRd),
    .o_MemAddr   (o_MemAddr),
    .i_MemData   (i_MemData),
    .i_MemReady  (i_MemReady),
    .o_PC        (o_PC),
    .o_Inst      (o_Inst),
    .o_DbgTag    (o_DbgTag)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign i_MemData = memf(o_MemAddr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1; i_Stall = 1'b0; i_Redirect = 1'b0; i_MemReady = 1'b0;
    tick(); tick();
    i_Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_MemReady = 1'b1; i_Stall = 1'b0; i_Redirect = 1'b0;
    tick(); tick();
    tests++;
    if (o_MemRd !== 1'b0) begin fails++; $display("FAIL reset_memrd: got %b want 0", o_MemRd); end
    tests++;
    if (o_PC !== 32'h0 || o_Inst !== NOP || o_DbgTag !== 3'd0) begin
      fails++; $display("FAIL reset_slot: got pc=%h inst=%h tag=%0d want bubble", o_PC, o_Inst, o_DbgTag);
    end
    i_Reset = 1'b0;
    #1;
    tests++;
    if (o_MemRd !== 1'b1 || o_MemAddr !== 32'h0) begin
      fails++; $display("FAIL reset_first_req: got rd=%b addr=%h want 1/0", o_MemRd, o_MemAddr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    i_MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (o_MemAddr !== 32'(4 * i)) begin
        fails++; $display("FAIL seq_addr%0d: got %h want %h", i, o_MemAddr, 32'(4 * i));
      end
      tick();
      tests++;
      if (o_PC !== 32'(4 * i) || o_DbgTag !== 3'(i + 1) || o_Inst !== memf(32'(4 * i))) begin
        fails++; $display("FAIL seq_slot%0d: got pc=%h tag=%0d inst=%h want pc=%h tag=%0d inst=%h",
                          i, o_PC, o_DbgTag, o_Inst, 32'(4 * i), i + 1, memf(32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    i_MemReady = 1'b1;
    tick(); tick();
    i_Stall = 1'b1;
    tests++;
    if (o_MemRd !== 1'b1 || o_MemAddr !== 32'h8) begin
      fails++; $display("FAIL stall_req8: got rd=%b addr=%h want 1/8", o_MemRd, o_MemAddr);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) i_Stall = 1'b1;
      tick();
      if (i == 2) i_Stall = 1'b0;
      tests++;
      if (o_PC !== 32'h4 || o_DbgTag !== 3'd2 || o_MemRd !== 1'b0) begin
        fails++; $display("FAIL stall_hold%0d: got pc=%h tag=%0d rd=%b want 4/2/0", i, o_PC, o_DbgTag, o_MemRd);
      end
    end
    tick();
    tests++;
    if (o_PC !== 32'h8 || o_Inst !== memf(32'h8) || o_DbgTag !== 3'd3 || o_MemAddr !== 32'hC) begin
      fails++; $display("FAIL stall_release: got pc=%h inst=%h tag=%0d addr=%h want 8/%h/3/c",
                        o_PC, o_Inst, o_DbgTag, o_MemAddr, memf(32'h8));
    end
    tick();
    tests++;
    if (o_PC !== 32'hC || o_DbgTag !== 3'd4) begin
      fails++; $display("FAIL stall_next: got pc=%h tag=%0d want c/4", o_PC, o_DbgTag);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 2; w++) begin
        i_MemReady = 1'b0;
        tick();
        tests++;
        if (o_PC !== 32'h0 || o_Inst !== NOP || o_DbgTag !== 3'd0 || o_MemAddr !== 32'(4 * k) || o_MemRd !== 1'b1) begin
          fails++; $display("FAIL wait_bubble%0d_%0d: got pc=%h inst=%h tag=%0d addr=%h rd=%b",
                            k, w, o_PC, o_Inst, o_DbgTag, o_MemAddr, o_MemRd);
        end
      end
      i_MemReady = 1'b1;
      tick();
      tests++;
      if (o_PC !== 32'(4 * k) || o_Inst !== memf(32'(4 * k)) || o_DbgTag !== 3'(k + 1)) begin
        fails++; $display("FAIL wait_inst%0d: got pc=%h tag=%0d want pc=%h tag=%0d", k, o_PC, o_DbgTag, 32'(4 * k), k + 1);
      end
    end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    i_MemReady = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    i_MemReady = 1'b0; i_Redirect = 1'b1; i_RedirectPC = 32'h100;
    tick();
    i_Redirect = 1'b0;
    tests++;
    if (o_MemAddr !== 32'h20 || o_MemRd !== 1'b1 || o_DbgTag !== 3'd0 || o_Inst !== NOP) begin
      fails++; $display("FAIL disc_pending1: got addr=%h rd=%b tag=%0d inst=%h want 20/1/0/nop", o_MemAddr, o_MemRd, o_DbgTag, o_Inst);
    end
    tick();
    tests++;
    if (o_MemAddr !== 32'h20 || o_DbgTag !== 3'd0) begin
      fails++; $display("FAIL disc_pending2: got addr=%h tag=%0d want 20/0", o_MemAddr, o_DbgTag);
    end
    i_MemReady = 1'b1;
    tick();
    tests++;
    if (o_MemAddr !== 32'h100 || o_DbgTag !== 3'd0 || o_PC !== 32'h0) begin
      fails++; $display("FAIL disc_drop: got addr=%h tag=%0d pc=%h want 100/0/0", o_MemAddr, o_DbgTag, o_PC);
    end
    tick();
    tests++;
    if (o_PC !== 32'h100 || o_Inst !== memf(32'h100) || o_DbgTag !== 3'd2) begin
      fails++; $display("FAIL disc_target: got pc=%h inst=%h tag=%0d want 100/%h/2", o_PC, o_Inst, o_DbgTag, memf(32'h100));
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    i_MemReady = 1'b1;
    tick(); tick();
    i_Stall = 1'b1;
    tick();
    i_Redirect = 1'b1; i_RedirectPC = 32'h203;
    tick();
    i_Redirect = 1'b0;
    tests++;
    if (o_DbgTag !== 3'd0 || o_Inst !== NOP || o_MemRd !== 1'b1 || o_MemAddr !== 32'h200) begin
      fails++; $display("FAIL hold_redirect: got tag=%0d inst=%h rd=%b addr=%h want 0/nop/1/200", o_DbgTag, o_Inst, o_MemRd, o_MemAddr);
    end
    i_Stall = 1'b0;
    tick();
    tests++;
    if (o_PC !== 32'h200 || o_Inst !== memf(32'h200) || o_DbgTag !== 3'd3) begin
      fails++; $display("FAIL hold_target: got pc=%h inst=%h tag=%0d want 200/%h/3", o_PC, o_Inst, o_DbgTag, memf(32'h200));
    end
  endtask

  task automatic test_tag_wrap();
    logic [2:0] exp_tags [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    do_reset();
    i_MemReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      tests++;
      if (o_DbgTag !== exp_tags[i]) begin
        fails++; $display("FAIL tag_wrap%0d: got %0d want %0d", i, o_DbgTag, exp_tags[i]);
      end
    end
  endtask

  // Program-order scoreboard: each delivered instruction must be the next
  // expected PC with memory contents, tags follow delivery count mod 7.
  task automatic test_random();
    logic [31:0] exp_pc;
    int          delivered;
    logic        p_rd;
    logic [31:0] p_addr, p_pc, p_inst;
    logic [2:0]  p_tag;
    do_reset();
    exp_pc = 32'h0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      i_Stall      = ($urandom_range(0, 9) < 3);
      i_MemReady   = ($urandom_range(0, 9) < 6);
      i_Redirect   = ($urandom_range(0, 19) == 0);
      i_RedirectPC = $urandom;
      p_rd = o_MemRd; p_addr = o_MemAddr; p_pc = o_PC; p_inst = o_Inst; p_tag = o_DbgTag;
      tick();
      if (p_rd && !i_MemReady) begin
        tests++;
        if (o_MemRd !== 1'b1 || o_MemAddr !== p_addr) begin
          fails++; $display("FAIL rnd_addr_stable c%0d: got rd=%b addr=%h want 1/%h", c, o_MemRd, o_MemAddr, p_addr);
        end
      end
      tests++;
      if (i_Redirect) begin
        exp_pc = i_RedirectPC & 32'hFFFF_FFFC;
        if (o_DbgTag !== 3'd0 || o_PC !== 32'h0 || o_Inst !== NOP) begin
          fails++; $display("FAIL rnd_redirect_bubble c%0d: got pc=%h inst=%h tag=%0d", c, o_PC, o_Inst, o_DbgTag);
        end
      end else if (i_Stall) begin
        if (o_PC !== p_pc || o_Inst !== p_inst || o_DbgTag !== p_tag) begin
          fails++; $display("FAIL rnd_stall_hold c%0d: got pc=%h tag=%0d want pc=%h tag=%0d", c, o_PC, o_DbgTag, p_pc, p_tag);
        end
      end else if (o_DbgTag === 3'd0) begin
        if (o_PC !== 32'h0 || o_Inst !== NOP) begin
          fails++; $display("FAIL rnd_bubble c%0d: got pc=%h inst=%h", c, o_PC, o_Inst);
        end
      end else begin
        if (o_PC !== exp_pc || o_Inst !== memf(exp_pc) || o_DbgTag !== 3'((delivered % 7) + 1)) begin
          fails++; $display("FAIL rnd_deliver c%0d: got pc=%h inst=%h tag=%0d want pc=%h inst=%h tag=%0d",
                            c, o_PC, o_Inst, o_DbgTag, exp_pc, memf(exp_pc), (delivered % 7) + 1);
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    tests++;
    if (delivered < 200) begin
      fails++; $display("FAIL rnd_progress: got %0d instructions want at least 200", delivered);
    end
    i_Redirect = 1'b0; i_Stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_wait_states();
    test_redirect_discard();
    test_redirect_hold();
    test_tag_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
